// File: rtl/jt49_pkg.sv
`default_nettype none
// ============================================================================
// jt49_pkg : shared constants and helpers for the multi-channel PSG divider
// Rev 1.0
// ============================================================================
package jt49_pkg;

  localparam int JT49_DIVW = 12;

  // Value a W-bit divider counter restarts from.
  function automatic int unsigned one(input int unsigned w);
    return (w != 0) ? 1 : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt49_div_ch.sv
`default_nettype none
// ============================================================================
// jt49_div_ch : one channel of the PSG clock-enable divider with shadowed period
// Rev 1.0
// ============================================================================
module jt49_div_ch
  import jt49_pkg::*;
#(
  parameter int W = JT49_DIVW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic [W-1:0] period,
  input  logic         restart,
  output logic         cen_div,
  output logic         sq
);

  localparam logic [W-1:0] CNT_ONE = W'(one(W));

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] per_lat_q, per_lat_d;
  logic         div_q, div_d;
  logic         sq_q, sq_d;
  logic         cen_div_q;

  always_comb begin
    count_d   = count_q;
    per_lat_d = per_lat_q;
    div_d     = div_q;
    sq_d      = sq_q;
    if (restart) begin
      count_d   = CNT_ONE;
      div_d     = 1'b0;
      sq_d      = 1'b0;
      per_lat_d = period;
    end else if (cen) begin
      if (per_lat_q == '0) begin
        per_lat_d = period;
        count_d   = CNT_ONE;
        div_d     = 1'b0;
      end else if (count_q >= per_lat_q) begin
        // '>=' keeps a shrunken period from letting the counter run to wrap
        count_d   = CNT_ONE;
        div_d     = 1'b1;
        sq_d      = ~sq_q;
        per_lat_d = period;
      end else begin
        count_d   = count_q + CNT_ONE;
        div_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= CNT_ONE;
      per_lat_q <= '0;
      div_q     <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      per_lat_q <= per_lat_d;
      div_q     <= div_d;
      sq_q      <= sq_d;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) cen_div_q <= 1'b0;
    else        cen_div_q <= div_q;
  end

  assign cen_div = cen_div_q;
  assign sq      = sq_q;

endmodule
`default_nettype wire

// File: rtl/jt49_div_multi.sv
`default_nettype none
// ============================================================================
// jt49_div_multi : CH independent programmable clock-enable dividers
// Rev 1.0
// ============================================================================
module jt49_div_multi
  import jt49_pkg::*;
#(
  parameter int W  = JT49_DIVW,
  parameter int CH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic [CH*W-1:0] period,
  input  logic [CH-1:0]   restart,
  output logic [CH-1:0]   cen_div,
  output logic [CH-1:0]   sq
);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    jt49_div_ch #(.W(W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .period  (period[k*W +: W]),
      .restart (restart[k]),
      .cen_div (cen_div[k]),
      .sq      (sq[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_jt49_div_multi.sv
`default_nettype none
// ============================================================================
// tb_jt49_div_multi : directed self-checking bench for jt49_div_multi
// Rev 1.0
// ============================================================================
module tb_jt49_div_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [35:0] period;
  logic [2:0]  restart;
  logic [2:0]  cen_div;
  logic [2:0]  sq;

  logic [3:0]  p4;
  logic [0:0]  restart4;
  logic [0:0]  cen_div4;
  logic [0:0]  sq4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  jt49_div_multi #(.W(12), .CH(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .period  (period),
    .restart (restart),
    .cen_div (cen_div),
    .sq      (sq)
  );

  jt49_div_multi #(.W(4), .CH(1)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .period  (p4),
    .restart (restart4),
    .cen_div (cen_div4),
    .sq      (sq4)
  );

  // One active edge, then sample just after the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // period = {0,5,1}, cen high; cycle n=1 is the load edge.
  task automatic run_basic(input int cycles);
    logic d0, d1, s0, s1;
    for (int n = 1; n <= cycles; n++) begin
      tick();
      d0 = (n >= 2);
      s0 = ((n - 1) % 2) == 1;
      d1 = (n > 1) && ((n - 1) % 5 == 0);
      s1 = (((n - 1) / 5) % 2) == 1;
      chk("basic", {10'd0, cen_div, sq}, {10'd0, 1'b0, d1, d0, 1'b0, s1, s0});
    end
  endtask

  initial begin
    logic d, s;
    rst_n    = 1'b0;
    cen      = 1'b0;
    period   = '0;
    restart  = '0;
    p4       = '0;
    restart4 = '0;

    repeat (3) tick();
    chk("rst_cen_div", {13'd0, cen_div}, 16'd0);
    chk("rst_sq", {13'd0, sq}, 16'd0);

    rst_n  = 1'b1;
    period = {12'd0, 12'd5, 12'd1};
    cen    = 1'b1;
    run_basic(26);

    // Async reset mid-count: outputs clear with no clock edge.
    rst_n = 1'b0;
    #1;
    chk("async_rst_cen_div", {13'd0, cen_div}, 16'd0);
    chk("async_rst_sq", {13'd0, sq}, 16'd0);
    #1;
    rst_n = 1'b1;
    run_basic(12);

    // Shadow reload on ch1: 8 then 3 (changed at count=2), then back to 8.
    period[12 +: 12] = 12'd8;
    restart = 3'b010;
    tick();
    restart = 3'b000;
    chk("shadow_restart", {13'd0, cen_div[1], sq[1], cen_div[0]}, 16'b001);
    s = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      d = (k == 8) || (k == 11) || (k == 14) || (k == 17) || (k == 25);
      if (d) s = ~s;
      chk("shadow", {13'd0, cen_div[1], sq[1], cen_div[0]}, {13'd0, d, s, 1'b1});
      if (k == 1)  period[12 +: 12] = 12'd3;
      if (k == 14) period[12 +: 12] = 12'd8;
    end

    // Restart ch1 at count=6 with cen low.
    cen     = 1'b0;
    restart = 3'b010;
    tick();
    restart = 3'b000;
    chk("restart_nocen", {13'd0, cen_div[1], sq[1], cen_div[0]}, 16'b001);
    cen = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("restart_next", {14'd0, cen_div[1], cen_div[0]}, {14'd0, (j == 8), 1'b1});
    end

    // cen high one cycle in four, ch1 period 3.
    period[12 +: 12] = 12'd3;
    restart = 3'b010;
    tick();
    restart = 3'b000;
    for (int c = 1; c <= 27; c++) begin
      cen = (c % 4 == 0);
      tick();
      d = (c >= 12 && c < 16) || (c >= 24 && c < 28);
      chk("cen_gating", {14'd0, cen_div[1], cen_div[0]}, {14'd0, d, 1'b1});
    end
    cen = 1'b1;

    // Stop at terminal (5 -> 0), then resume with period 2.
    period[12 +: 12] = 12'd5;
    restart = 3'b010;
    tick();
    restart = 3'b000;
    s = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      d = (k == 5) || (k == 15) || (k == 17);
      if (d) s = ~s;
      chk("stop_start", {14'd0, cen_div[1], sq[1]}, {14'd0, d, s});
      if (k == 1)  period[12 +: 12] = 12'd0;
      if (k == 12) period[12 +: 12] = 12'd2;
    end

    // W=4 at maximum period: no wrap, pulse every 15.
    p4       = 4'd15;
    restart4 = 1'b1;
    tick();
    restart4 = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      chk("w4_max", {14'd0, cen_div4, sq4}, {14'd0, (k % 15 == 0), ((k / 15) % 2 == 1)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
